// File: rtl/nios2_system_pixel_pack_writer_pkg.sv
// Shared types and constants for the pixel pack writer: FSM encoding, memory geometry
// and the byte-lane mask helper.
package nios2_system_pixel_pack_writer_pkg;

   localparam int unsigned ADDR_W         = 15;
   localparam int unsigned DEPTH_WORDS    = 20000;
   localparam int unsigned LEN_W          = 15;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned PIX_W          = 8;
   localparam int unsigned DATA_W         = BYTES_PER_WORD * PIX_W;
   localparam int unsigned LANE_W         = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_PACK     = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0]         data;
      logic [BYTES_PER_WORD-1:0] be;
   } word_t;

   // Mask with the low n lanes set (n = 0..4)
   function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [2:0] n);
      return 4'((5'd1 << n) - 5'd1);
   endfunction

endpackage

// File: rtl/nios2_system_pixel_pack_writer_if.sv
// Pixel stream in plus memory write port out; the slave modport is the writer's view.
interface nios2_system_pixel_pack_writer_if #(
   parameter int unsigned ADDR_W = 15
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              in_sof;
   logic              in_eof;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              mem_clken;

   modport slave (
      input  in_valid, in_data, in_sof, in_eof,
      output in_ready,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
   );

   modport master (
      output in_valid, in_data, in_sof, in_eof,
      input  in_ready,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
   );
endinterface

// File: rtl/nios2_system_pixel_packer.sv
// Packs 8-bit pixels little-endian into 32-bit words and reports completed or flushed
// words combinationally for the top level to register.
module nios2_system_pixel_packer
   import nios2_system_pixel_pack_writer_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear_i,
   input  logic                      beat_i,
   input  logic                      restart_i,
   input  logic                      last_i,
   input  logic                      flush_i,
   input  logic [PIX_W-1:0]          data_i,
   output logic                      wr_c,
   output logic [DATA_W-1:0]         wdata_c,
   output logic [BYTES_PER_WORD-1:0] be_c
);

   logic [LANE_W-1:0] lane_q, lane_d, base_lane;
   logic [DATA_W-1:0] word_q, word_d, base_word, merged;
   logic              flush_old;

   always_comb begin
      lane_d    = lane_q;
      word_d    = word_q;
      wr_c      = 1'b0;
      wdata_c   = '0;
      be_c      = '0;
      base_lane = restart_i ? '0 : lane_q;
      base_word = restart_i ? '0 : word_q;
      merged    = base_word | (DATA_W'(data_i) << {base_lane, 3'b000});
      flush_old = (flush_i | (beat_i & restart_i)) & (lane_q != '0);

      if (clear_i) begin
         lane_d = '0;
         word_d = '0;
      end else begin
         if (flush_old) begin
            wr_c    = 1'b1;
            wdata_c = word_q;
            be_c    = lane_mask(3'(lane_q));
            lane_d  = '0;
            word_d  = '0;
         end
         // A restart beat that also closes cannot share the cycle with a flush; it stays
         // buffered and is flushed from DONE.
         if (beat_i) begin
            if ((base_lane == LANE_W'(BYTES_PER_WORD - 1) || last_i) && !flush_old) begin
               wr_c    = 1'b1;
               wdata_c = merged;
               be_c    = lane_mask(3'(base_lane) + 3'd1);
               lane_d  = '0;
               word_d  = '0;
            end else begin
               lane_d = base_lane + LANE_W'(1);
               word_d = merged;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/nios2_system_pixel_pack_writer.sv
// Captures one framed pixel stream into on-chip memory as packed 32-bit words,
// with address wrap at DEPTH_WORDS and a per-frame word limit.
module nios2_system_pixel_pack_writer #(
   parameter int unsigned ADDR_W      = nios2_system_pixel_pack_writer_pkg::ADDR_W,
   parameter int unsigned DEPTH_WORDS = nios2_system_pixel_pack_writer_pkg::DEPTH_WORDS,
   parameter int unsigned LEN_W       = nios2_system_pixel_pack_writer_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length_words,
   input  logic              hold,
   nios2_system_pixel_pack_writer_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [LEN_W-1:0]  words_written
);
   import nios2_system_pixel_pack_writer_pkg::*;

   state_e                    state_q, state_d;
   logic                      in_ready_q, in_ready_d;
   logic                      busy_q, done_q, overflow_q, bad_q;
   logic [LEN_W-1:0]          words_q, len_q;
   logic [ADDR_W-1:0]         addr_q, mem_addr_q, addr_inc_c;
   logic                      mem_write_q;
   logic [BYTES_PER_WORD-1:0] mem_be_q;
   logic [DATA_W-1:0]         mem_data_q;

   logic                      accept_c, start_acc_c, base_bad_c;
   logic                      pk_beat_c, pk_restart_c, pk_last_c, pk_flush_c, pk_clear_c;
   logic                      pk_wr_c;
   logic [DATA_W-1:0]         pk_data_c;
   logic [BYTES_PER_WORD-1:0] pk_be_c;
   logic                      limit_c, issue_c, drop_c;

   nios2_system_pixel_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (pk_clear_c),
      .beat_i    (pk_beat_c),
      .restart_i (pk_restart_c),
      .last_i    (pk_last_c),
      .flush_i   (pk_flush_c),
      .data_i    (bus.in_data),
      .wr_c      (pk_wr_c),
      .wdata_c   (pk_data_c),
      .be_c      (pk_be_c)
   );

   assign accept_c   = bus.in_valid & in_ready_q;
   assign base_bad_c = 32'(base_addr) >= DEPTH_WORDS;
   assign limit_c    = (words_q == len_q);
   assign issue_c    = pk_wr_c & ~limit_c & ~bad_q;
   assign drop_c     = pk_wr_c & ~issue_c;
   assign addr_inc_c = (32'(addr_q) == DEPTH_WORDS - 1) ? '0 : addr_q + ADDR_W'(1);

   // Frame sequencing; in_ready is registered so it follows hold one cycle later
   always_comb begin
      state_d      = state_q;
      start_acc_c  = 1'b0;
      pk_beat_c    = 1'b0;
      pk_restart_c = 1'b0;
      pk_last_c    = 1'b0;
      pk_flush_c   = 1'b0;
      pk_clear_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_acc_c = 1'b1;
               pk_clear_c  = 1'b1;
               state_d     = ST_WAIT_SOF;
            end
         end
         ST_WAIT_SOF: begin
            if (accept_c && bus.in_sof) begin
               pk_beat_c    = 1'b1;
               pk_restart_c = 1'b1;
               pk_last_c    = bus.in_eof;
               state_d      = bus.in_eof ? ST_DONE : ST_PACK;
            end
         end
         ST_PACK: begin
            if (accept_c) begin
               pk_beat_c    = 1'b1;
               pk_restart_c = bus.in_sof;
               pk_last_c    = bus.in_eof;
               if (bus.in_eof) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            pk_flush_c = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = ((state_d == ST_WAIT_SOF) || (state_d == ST_PACK)) && !hold;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         bad_q       <= 1'b0;
         words_q     <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         mem_addr_q  <= '0;
         mem_write_q <= 1'b0;
         mem_be_q    <= '0;
         mem_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_q == ST_DONE);
         mem_write_q <= issue_c;
         if (issue_c) begin
            mem_addr_q <= addr_q;
            mem_data_q <= pk_data_c;
            mem_be_q   <= pk_be_c;
         end else begin
            mem_data_q <= '0;
            mem_be_q   <= '0;
         end
         // Out-of-range base keeps the frame running but suppresses every write
         if (start_acc_c) begin
            addr_q     <= base_addr;
            len_q      <= length_words;
            words_q    <= '0;
            bad_q      <= base_bad_c;
            overflow_q <= base_bad_c;
         end else begin
            if (issue_c) begin
               addr_q  <= addr_inc_c;
               words_q <= words_q + LEN_W'(1);
            end
            if (drop_c) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.mem_address    = mem_addr_q;
   assign bus.mem_byteenable = mem_be_q;
   assign bus.mem_chipselect = mem_write_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_writedata  = mem_data_q;
   assign bus.mem_clken      = 1'b1;
   assign busy               = busy_q;
   assign done               = done_q;
   assign overflow           = overflow_q;
   assign words_written      = words_q;

endmodule
